// File: rtl/data_mem_responder.sv
// Word-addressed data memory responder with a fixed multi-cycle access latency.
// Handles big-endian byte/half stores by read-modify-write and flags misaligned or out-of-range accesses.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] data_address_2DM,
  input  logic [31:0] data_write_2DM,
  input  logic [1:0]  data_write_size_2DM,
  input  logic        MemRead_2DM,
  input  logic        MemWrite_2DM,
  output logic [31:0] data_read_fDM,
  output logic        MemStall_fDM,
  output logic        MemError_fDM
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, wdata_q;
  logic [1:0]  size_q;
  logic        rd_q, wr_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic          req, fire, oob, fault, mem_we;
  logic [AW-1:0] widx;
  logic [1:0]    off;
  logic [31:0]   cur_word, merged;

  assign req      = MemRead_2DM | MemWrite_2DM;
  assign fire     = (state_q == ACCESS) && (cnt_q == 4'd0);
  assign widx     = addr_q[AW+1:2];
  assign off      = addr_q[1:0];
  assign cur_word = mem[widx];

  // Fault detection and sub-word merge, evaluated on the latched request
  always_comb begin
    oob    = {2'b00, addr_q[31:2]} >= 32'(DEPTH_WORDS);
    fault  = oob;
    merged = cur_word;
    if (wr_q) begin
      unique case (size_q)
        2'd0: begin
          fault  = oob | (off != 2'd0);
          merged = wdata_q;
        end
        2'd1: begin
          unique case (off)
            2'd0: merged[31:24] = wdata_q[7:0];
            2'd1: merged[23:16] = wdata_q[7:0];
            2'd2: merged[15:8]  = wdata_q[7:0];
            default: merged[7:0] = wdata_q[7:0];
          endcase
        end
        2'd2: begin
          fault = oob | off[0];
          if (off[1]) merged[15:0] = wdata_q[15:0];
          else        merged[31:16] = wdata_q[15:0];
        end
        default: fault = 1'b1;
      endcase
    end
  end

  assign mem_we = fire & wr_q & ~fault;

  // Storage survives reset; async reset pulls state to IDLE so no write can fire
  always_ff @(posedge CLK) begin
    if (mem_we) mem[widx] <= merged;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req) state_d = ACCESS;
      ACCESS:  if (cnt_q == 4'd0) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    MemStall_fDM = ~RESET & (((state_q == IDLE) & req) | (state_q == ACCESS));
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE && req)                  cnt_d = 4'(LATENCY - 1);
    else if (state_q == ACCESS && cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      size_q  <= 2'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (state_q == IDLE && req) begin
        addr_q  <= data_address_2DM;
        wdata_q <= data_write_2DM;
        size_q  <= data_write_size_2DM;
        wr_q    <= MemWrite_2DM;
        rd_q    <= MemRead_2DM & ~MemWrite_2DM;
      end
      if (fire && rd_q) rdata_q <= fault ? 32'd0 : cur_word;
      err_q <= fire & fault;
    end
  end

  assign data_read_fDM = rdata_q;
  assign MemError_fDM  = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (latency 2 and latency 1) checked against
// a word-array reference model of the store/load rules.
module tb_data_mem_responder;

  localparam int DEPTH = 1024;
  localparam int LAT0  = 2;
  localparam int LAT1  = 1;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  logic [31:0] a0, d0, q0, a1, d1, q1;
  logic [1:0]  sz0, sz1;
  logic        rd0, wr0, st0, er0, rd1, wr1, st1, er1;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT0)) u_dut0 (
    .CLK(CLK), .RESET(RESET),
    .data_address_2DM(a0), .data_write_2DM(d0), .data_write_size_2DM(sz0),
    .MemRead_2DM(rd0), .MemWrite_2DM(wr0),
    .data_read_fDM(q0), .MemStall_fDM(st0), .MemError_fDM(er0)
  );

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT1)) u_dut1 (
    .CLK(CLK), .RESET(RESET),
    .data_address_2DM(a1), .data_write_2DM(d1), .data_write_size_2DM(sz1),
    .MemRead_2DM(rd1), .MemWrite_2DM(wr1),
    .data_read_fDM(q1), .MemStall_fDM(st1), .MemError_fDM(er1)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] mdl [2][16];
  logic [31:0] last_rd [2];

  function automatic logic get_st(input int w);
    return (w == 0) ? st0 : st1;
  endfunction

  function automatic logic get_er(input int w);
    return (w == 0) ? er0 : er1;
  endfunction

  function automatic logic [31:0] get_q(input int w);
    return (w == 0) ? q0 : q1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  task automatic set_in(input int w, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    if (w == 0) begin
      rd0 = rd; wr0 = wr; a0 = a; d0 = d; sz0 = sz;
    end else begin
      rd1 = rd; wr1 = wr; a1 = a; d1 = d; sz1 = sz;
    end
  endtask

  // Reference: memory as an array of words, lanes addressed big-endian
  task automatic model_apply(input int w, input logic rd, input logic wr,
                             input logic [31:0] a, input logic [31:0] d,
                             input logic [1:0] sz, output logic e);
    logic [31:0] idx;
    logic [31:0] word;
    int off, sh;
    idx = a >> 2;
    off = int'(a % 4);
    e = (idx >= 32'(DEPTH));
    if (wr) begin
      if (sz == 2'd0 && off != 0) e = 1'b1;
      if (sz == 2'd2 && (off % 2) != 0) e = 1'b1;
      if (sz == 2'd3) e = 1'b1;
      if (!e) begin
        word = mdl[w][idx[3:0]];
        if (sz == 2'd0) begin
          word = d;
        end else if (sz == 2'd1) begin
          sh = (3 - off) * 8;
          word = (word & ~(32'hFF << sh)) | ((d & 32'hFF) << sh);
        end else begin
          sh = (off == 0) ? 16 : 0;
          word = (word & ~(32'hFFFF << sh)) | ((d & 32'hFFFF) << sh);
        end
        mdl[w][idx[3:0]] = word;
      end
    end else if (rd) begin
      last_rd[w] = e ? 32'd0 : mdl[w][idx[3:0]];
    end
  endtask

  // Called at a negedge; returns at the negedge of the DONE cycle with inputs still applied
  task automatic txn(input int w, input logic rd, input logic wr,
                     input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                     input string tag);
    int n;
    bit done;
    logic e;
    set_in(w, rd, wr, a, d, sz);
    #1;
    n = get_st(w) ? 1 : 0;
    done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge CLK);
      if (get_st(w)) n++;
      else done = 1'b1;
    end
    model_apply(w, rd, wr, a, d, sz, e);
    chk({tag, "_timeout"}, 32'(done), 32'd1);
    chk({tag, "_stall"}, 32'(n), 32'(((w == 0) ? LAT0 : LAT1) + 1));
    chk({tag, "_err"}, 32'(get_er(w)), 32'(e));
    chk({tag, "_rdata"}, get_q(w), last_rd[w]);
  endtask

  task automatic idle_cycle(input int w);
    set_in(w, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0);
    @(negedge CLK);
    chk("idle_stall", 32'(get_st(w)), 32'd0);
    chk("idle_err", 32'(get_er(w)), 32'd0);
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 32'h1000 + 32'($urandom_range(0, 15));
    if (r == 1) return $urandom | 32'h8000_0000;
    return 32'($urandom_range(0, 63));
  endfunction

  initial begin
    int op;
    logic [31:0] ra;
    last_rd[0] = 32'd0;
    last_rd[1] = 32'd0;
    RESET = 1'b1;
    set_in(0, 1'b1, 1'b0, 32'h10, 32'd0, 2'd0);
    set_in(1, 1'b0, 1'b1, 32'h10, 32'd0, 2'd0);
    repeat (3) @(negedge CLK);
    chk("rst_stall0", 32'(st0), 32'd0);
    chk("rst_stall1", 32'(st1), 32'd0);
    chk("rst_rdata0", q0, 32'd0);
    chk("rst_err0", 32'(er0), 32'd0);
    set_in(0, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0);
    set_in(1, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0);
    RESET = 1'b0;
    @(negedge CLK);

    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 16; i++) begin
        txn(w, 1'b0, 1'b1, 32'(i * 4), $urandom, 2'd0, "init");
        idle_cycle(w);
      end
    end

    txn(0, 1'b0, 1'b1, 32'h10, 32'h12345678, 2'd0, "wr_word");   idle_cycle(0);
    txn(0, 1'b1, 1'b0, 32'h10, 32'd0, 2'd0, "rd_word");           idle_cycle(0);
    chk("rd_word_lit", last_rd[0], 32'h12345678);
    txn(0, 1'b0, 1'b1, 32'h11, 32'h000000AB, 2'd1, "wr_byte");   idle_cycle(0);
    txn(0, 1'b1, 1'b0, 32'h13, 32'd0, 2'd0, "rd_byte");           idle_cycle(0);
    chk("rd_byte_lit", last_rd[0], 32'h12AB5678);
    txn(0, 1'b0, 1'b1, 32'h10, 32'h12345678, 2'd0, "wr_word2");  idle_cycle(0);
    txn(0, 1'b0, 1'b1, 32'h12, 32'h0000BEEF, 2'd2, "wr_half");   idle_cycle(0);
    txn(0, 1'b1, 1'b0, 32'h10, 32'd0, 2'd0, "rd_half");           idle_cycle(0);
    chk("rd_half_lit", last_rd[0], 32'h1234BEEF);
    txn(0, 1'b0, 1'b1, 32'h11, 32'h00001111, 2'd2, "half_mis");  idle_cycle(0);
    txn(0, 1'b1, 1'b0, 32'h10, 32'd0, 2'd0, "rd_after_mis");      idle_cycle(0);
    txn(0, 1'b1, 1'b0, 32'(DEPTH * 4), 32'd0, 2'd0, "rd_oob");    idle_cycle(0);
    txn(0, 1'b1, 1'b1, 32'h20, 32'hCAFEDEAD, 2'd0, "rdwr_both"); idle_cycle(0);
    txn(0, 1'b1, 1'b0, 32'h20, 32'd0, 2'd0, "rd_both");           idle_cycle(0);
    txn(0, 1'b0, 1'b1, 32'h24, 32'h55555555, 2'd3, "wr_size3");  idle_cycle(0);
    txn(0, 1'b0, 1'b1, 32'h26, 32'h66666666, 2'd0, "word_mis");  idle_cycle(0);
    txn(0, 1'b1, 1'b0, 32'h24, 32'd0, 2'd0, "rd_after_size3");    idle_cycle(0);

    // Reset in the middle of a word store must abort it
    set_in(0, 1'b0, 1'b1, 32'h10, 32'hFFFFFFFF, 2'd0);
    @(negedge CLK);
    chk("abort_stall_pre", 32'(st0), 32'd1);
    RESET = 1'b1;
    #1;
    chk("abort_stall", 32'(st0), 32'd0);
    chk("abort_rdata", q0, 32'd0);
    chk("abort_err", 32'(er0), 32'd0);
    @(posedge CLK);
    @(negedge CLK);
    set_in(0, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0);
    RESET = 1'b0;
    last_rd[0] = 32'd0;
    last_rd[1] = 32'd0;
    idle_cycle(0);
    txn(0, 1'b1, 1'b0, 32'h10, 32'd0, 2'd0, "rd_after_abort");    idle_cycle(0);
    chk("rd_after_abort_lit", last_rd[0], 32'h1234BEEF);

    // Latency-1 instance: requests chained with no idle gap
    idle_cycle(1);
    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 2);
      ra = rand_addr();
      txn(1, op != 1, op != 0, ra, $urandom, 2'($urandom_range(0, 3)), "b2b");
    end
    idle_cycle(1);

    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 2);
      ra = rand_addr();
      txn(0, op != 1, op != 0, ra, $urandom, 2'($urandom_range(0, 3)), "rnd");
      if ($urandom_range(0, 1) == 1) idle_cycle(0);
    end
    idle_cycle(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
